hazard_unit: RTL and testbench

Pipeline hazard controller in the ID stage of the ARM control pipeline. It watches the instruction held in IF/ID, compares its source registers against a scoreboard of in-flight destination registers, and drives the PC enable, the IF/ID enable, the IF/ID flush, and the select of the control-unit bubble multiplexer. It sits directly upstream of the control-unit mux and of the ID/EX register, and replaces the hand-driven PC, IF/ID and mux-select stimulus used in bench bring-up.

---
 rtl/pipeline_pkg.sv | 49 ++++
 rtl/hazard_unit_src_decode.sv | 54 +++++
 rtl/hazard_unit.sv | 165 ++++++++++++++++
 tb/tb_hazard_unit.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared ID-stage definitions: opcode classes, field positions,
// NOP/link-register constants and the scoreboard entry type.
package pipeline_pkg;

  // Opcode classes (bits 27:26, or 27:25 for branches)
  localparam logic [1:0] OPC_DP   = 2'b00;
  localparam logic [1:0] OPC_LDST = 2'b01;
  localparam logic [2:0] OPC_BR   = 3'b101;

  // Instruction field positions
  localparam int CLS_MSB = 27;
  localparam int CLS_LSB = 26;
  localparam int BR_LSB  = 25;
  localparam int I_BIT   = 25;
  localparam int L_BIT   = 20;
  localparam int RN_MSB  = 19;
  localparam int RN_LSB  = 16;
  localparam int RD_MSB  = 15;
  localparam int RD_LSB  = 12;
  localparam int RM_MSB  = 3;
  localparam int RM_LSB  = 0;

  localparam logic [31:0] NOP_INSTR = 32'h0;
  localparam logic [3:0]  LR_IDX    = 4'd14;

  typedef struct packed {
    logic       valid;
    logic       is_load;
    logic [3:0] rd;
  } sb_entry_t;

  localparam sb_entry_t SB_EMPTY = '0;

  typedef enum logic {
    S_RUN,
    S_STALL
  } hz_state_e;

  // True when a used source register matches an in-flight load
  function automatic logic load_hit(
    input logic      used,
    input logic [3:0] src,
    input sb_entry_t e
  );
    return used && e.valid && e.is_load
        && (src == e.rd);
  endfunction

endpackage

// File: rtl/hazard_unit_src_decode.sv
// Combinational source/destination decode of the IF/ID instruction.
// Ports: i_instr in; o_rn*/o_rm*/o_rd* source fields + used flags, o_dst.
module src_decode
  import pipeline_pkg::*;
(
  input  logic [31:0] i_instr,
  output logic        o_rn_used,
  output logic [3:0]  o_rn,
  output logic        o_rm_used,
  output logic [3:0]  o_rm,
  output logic        o_rd_src_used,
  output logic [3:0]  o_rd,
  output logic [3:0]  o_dst
);

  logic w_nop;
  logic w_dp;
  logic w_ls;
  logic w_br;

  assign w_nop = (i_instr == NOP_INSTR);
  assign w_br  = (i_instr[CLS_MSB:BR_LSB] == OPC_BR);
  // The all-zero NOP also has class 00, so keep it out of DP
  assign w_dp  = (i_instr[CLS_MSB:CLS_LSB] == OPC_DP)
               && !w_nop;
  assign w_ls  = (i_instr[CLS_MSB:CLS_LSB] == OPC_LDST);

  assign o_rn  = i_instr[RN_MSB:RN_LSB];
  assign o_rm  = i_instr[RM_MSB:RM_LSB];
  assign o_rd  = i_instr[RD_MSB:RD_LSB];
  assign o_dst = w_br ? LR_IDX
                      : i_instr[RD_MSB:RD_LSB];

  always_comb begin
    o_rn_used     = 1'b0;
    o_rm_used     = 1'b0;
    o_rd_src_used = 1'b0;
    unique case (1'b1)
      w_nop: ;
      w_dp: begin
        o_rn_used = 1'b1;
        o_rm_used = !i_instr[I_BIT];
      end
      w_ls: begin
        o_rn_used     = 1'b1;
        o_rm_used     = i_instr[I_BIT];
        o_rd_src_used = !i_instr[L_BIT];
      end
      w_br: ;
      default: ;
    endcase
  end

endmodule

// File: rtl/hazard_unit.sv
// ID-stage load-use hazard / branch flush controller with a 3-entry scoreboard.
// Ports: clk, reset (async low), id_* from IF/ID + control unit; PC/IF-ID/mux controls, stall_count.
module hazard_unit
  import pipeline_pkg::*;
#(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int STALL_CNT_W       = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            id_instr,
  input  logic                   id_reg_write,
  input  logic                   id_mem_to_reg,
  input  logic                   id_pc_src,
  output logic                   pc_enable,
  output logic                   if_id_enable,
  output logic                   if_id_flush,
  output logic                   cu_mux_select,
  output logic [STALL_CNT_W-1:0] stall_count
);

  // Remaining stall cycles after the hazard cycle itself
  localparam logic [1:0] STALL_INIT =
    2'(LOAD_STALL_CYCLES - 1);

  hz_state_e r_state;
  hz_state_e w_state_nxt;
  logic [1:0] r_cnt;
  logic [1:0] w_cnt_nxt;

  sb_entry_t r_sb_ex;
  sb_entry_t r_sb_mem;
  sb_entry_t r_sb_wb;
  sb_entry_t w_sb_id;

  logic [STALL_CNT_W-1:0] r_stall_count;

  logic       w_rn_used;
  logic [3:0] w_rn;
  logic       w_rm_used;
  logic [3:0] w_rm;
  logic       w_rd_src_used;
  logic [3:0] w_rd;
  logic [3:0] w_dst;
  logic       w_hazard;
  logic       w_unused_wb;

  src_decode u_src_decode (
    .i_instr       (id_instr),
    .o_rn_used     (w_rn_used),
    .o_rn          (w_rn),
    .o_rm_used     (w_rm_used),
    .o_rm          (w_rm),
    .o_rd_src_used (w_rd_src_used),
    .o_rd          (w_rd),
    .o_dst         (w_dst)
  );

  // Only the EX slot can still produce a load result too late for ID;
  // MEM/WB loads are assumed forwarded/written back in time.
  assign w_hazard = reset && (
      load_hit(w_rn_used, w_rn, r_sb_ex)
   || load_hit(w_rm_used, w_rm, r_sb_ex)
   || load_hit(w_rd_src_used, w_rd, r_sb_ex));

  // WB is kept for pipeline visibility but not consulted
  assign w_unused_wb = ^r_sb_wb;

  always_comb begin
    w_sb_id         = SB_EMPTY;
    w_sb_id.valid   = id_reg_write;
    w_sb_id.is_load = id_mem_to_reg;
    w_sb_id.rd      = w_dst;
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_RUN;
      r_cnt   <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // FSM next state
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      S_RUN: begin
        if (w_hazard) begin
          w_cnt_nxt = STALL_INIT;
          if (STALL_INIT != 2'd0)
            w_state_nxt = S_STALL;
        end
      end
      S_STALL: begin
        if (r_cnt != 2'd0)
          w_cnt_nxt = r_cnt - 2'd1;
        if (r_cnt <= 2'd1)
          w_state_nxt = S_RUN;
      end
      default: begin
        w_state_nxt = S_RUN;
        w_cnt_nxt   = 2'd0;
      end
    endcase
  end

  // FSM outputs; reset forces idle values even mid-cycle
  always_comb begin
    pc_enable     = 1'b1;
    if_id_enable  = 1'b1;
    if_id_flush   = 1'b0;
    cu_mux_select = 1'b0;
    if (reset) begin
      unique case (r_state)
        S_RUN: begin
          if (w_hazard) begin
            pc_enable     = 1'b0;
            if_id_enable  = 1'b0;
            cu_mux_select = 1'b1;
          end else if (id_pc_src) begin
            if_id_flush = 1'b1;
          end
        end
        S_STALL: begin
          pc_enable     = 1'b0;
          if_id_enable  = 1'b0;
          cu_mux_select = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Scoreboard shift; a bubble enters EX as invalid
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sb_ex  <= SB_EMPTY;
      r_sb_mem <= SB_EMPTY;
      r_sb_wb  <= SB_EMPTY;
    end else begin
      r_sb_wb  <= r_sb_mem;
      r_sb_mem <= r_sb_ex;
      r_sb_ex  <= cu_mux_select ? SB_EMPTY
                                : w_sb_id;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_count <= '0;
    end else if (cu_mux_select
              && (r_stall_count != '1)) begin
      r_stall_count <= r_stall_count
                     + STALL_CNT_W'(1);
    end
  end

  assign stall_count = r_stall_count;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed table-driven bench for hazard_unit (stall lengths 1 and 3).
// Drives at negedge, samples 1ns later, compares against hand-computed rows.
module tb_hazard_unit;

  localparam logic [31:0] NOP     = 32'h0000_0000;
  localparam logic [31:0] LDRB_R2 = 32'hE7D1_2000;
  localparam logic [31:0] ADD_R2  = 32'hE082_5183;
  localparam logic [31:0] STR_R5  = 32'hE58A_5000;
  localparam logic [31:0] LDRB_R5 = 32'hE7D1_5000;
  localparam logic [31:0] BNE     = 32'h1AFF_FFFD;
  localparam logic [31:0] STR_R2  = 32'hE58A_2000;
  localparam logic [31:0] LDRB_R3 = 32'hE7D1_3000;
  localparam logic [31:0] ADDI    = 32'hE280_5003;
  localparam logic [31:0] ADD_R3  = 32'hE080_5183;
  localparam logic [31:0] LDRB_R0 = 32'hE7D1_0000;

  localparam int NV = 26;

  // ins  = {reg_write, mem_to_reg, pc_src}
  // outs = {pc_enable, if_id_enable, if_id_flush, cu_mux_select}
  typedef struct {
    logic [31:0] instr;
    logic [2:0]  ins;
    logic [3:0]  outs;
    int          cnt;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [31:0] instr;
  logic        rw, m2r, psrc;

  logic        pe1, ie1, fl1, mx1;
  logic [15:0] cnt1;
  logic        pe3, ie3, fl3, mx3;
  logic [15:0] cnt3;

  int total = 0;
  int bad   = 0;

  vec_t tv [NV];

  hazard_unit #(.LOAD_STALL_CYCLES(1), .STALL_CNT_W(16)) dut1 (
    .clk           (clk),
    .reset         (reset),
    .id_instr      (instr),
    .id_reg_write  (rw),
    .id_mem_to_reg (m2r),
    .id_pc_src     (psrc),
    .pc_enable     (pe1),
    .if_id_enable  (ie1),
    .if_id_flush   (fl1),
    .cu_mux_select (mx1),
    .stall_count   (cnt1)
  );

  hazard_unit #(.LOAD_STALL_CYCLES(3), .STALL_CNT_W(16)) dut3 (
    .clk           (clk),
    .reset         (reset),
    .id_instr      (instr),
    .id_reg_write  (rw),
    .id_mem_to_reg (m2r),
    .id_pc_src     (psrc),
    .pc_enable     (pe3),
    .if_id_enable  (ie3),
    .if_id_flush   (fl3),
    .cu_mux_select (mx3),
    .stall_count   (cnt3)
  );

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] i,
                       input logic [2:0] c);
    instr = i;
    {rw, m2r, psrc} = c;
  endtask

  initial begin
    tv[0]  = '{NOP,     3'b000, 4'b1100, 0};
    tv[1]  = '{LDRB_R2, 3'b110, 4'b1100, 0};
    tv[2]  = '{ADD_R2,  3'b100, 4'b0001, 0};
    tv[3]  = '{ADD_R2,  3'b100, 4'b1100, 1};
    tv[4]  = '{LDRB_R2, 3'b110, 4'b1100, 1};
    tv[5]  = '{STR_R5,  3'b000, 4'b1100, 1};
    tv[6]  = '{LDRB_R5, 3'b110, 4'b1100, 1};
    tv[7]  = '{STR_R5,  3'b000, 4'b0001, 1};
    tv[8]  = '{STR_R5,  3'b000, 4'b1100, 2};
    tv[9]  = '{BNE,     3'b001, 4'b1110, 2};
    tv[10] = '{NOP,     3'b000, 4'b1100, 2};
    tv[11] = '{LDRB_R2, 3'b110, 4'b1100, 2};
    tv[12] = '{ADD_R2,  3'b101, 4'b0001, 2};
    tv[13] = '{ADD_R2,  3'b101, 4'b1110, 3};
    tv[14] = '{NOP,     3'b000, 4'b1100, 3};
    tv[15] = '{LDRB_R2, 3'b110, 4'b1100, 3};
    tv[16] = '{ADD_R2,  3'b100, 4'b0001, 3};
    tv[17] = '{ADD_R2,  3'b100, 4'b1100, 4};
    tv[18] = '{STR_R2,  3'b000, 4'b1100, 4};
    tv[19] = '{LDRB_R3, 3'b110, 4'b1100, 4};
    tv[20] = '{ADDI,    3'b100, 4'b1100, 4};
    tv[21] = '{LDRB_R3, 3'b110, 4'b1100, 4};
    tv[22] = '{ADD_R3,  3'b100, 4'b0001, 4};
    tv[23] = '{ADD_R3,  3'b100, 4'b1100, 5};
    tv[24] = '{LDRB_R0, 3'b110, 4'b1100, 5};
    tv[25] = '{NOP,     3'b000, 4'b1100, 5};

    // Reset held for 3 cycles; a taken-branch input must not flush
    reset = 1'b0;
    drive(NOP, 3'b000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 1) drive(ADD_R2, 3'b101);
      else        drive(NOP, 3'b000);
      #1;
      chk("rst_out1", 32'({pe1, ie1, fl1, mx1}), 32'hC);
      chk("rst_cnt1", 32'(cnt1), 32'd0);
      chk("rst_out3", 32'({pe3, ie3, fl3, mx3}), 32'hC);
    end

    @(negedge clk);
    reset = 1'b1;
    drive(NOP, 3'b000);

    // Main table against the single-bubble instance
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(tv[i].instr, tv[i].ins);
      #1;
      chk($sformatf("vec%0d_out", i),
          32'({pe1, ie1, fl1, mx1}), 32'(tv[i].outs));
      chk($sformatf("vec%0d_cnt", i),
          32'(cnt1), 32'(tv[i].cnt));
    end

    // Three-bubble stall
    @(negedge clk);
    reset = 1'b0;
    drive(NOP, 3'b000);
    #1;
    chk("l3_rst", 32'({pe3, ie3, fl3, mx3}), 32'hC);
    @(negedge clk);
    reset = 1'b1;
    drive(LDRB_R2, 3'b110);
    #1;
    chk("l3_load", 32'({pe3, ie3, fl3, mx3}), 32'hC);
    @(negedge clk);
    drive(ADD_R2, 3'b100);
    #1;
    chk("l3_bub0", 32'({pe3, ie3, fl3, mx3}), 32'h1);
    for (int b = 1; b < 3; b++) begin
      @(negedge clk);
      #1;
      chk($sformatf("l3_bub%0d", b),
          32'({pe3, ie3, fl3, mx3}), 32'h1);
    end
    @(negedge clk);
    #1;
    chk("l3_done", 32'({pe3, ie3, fl3, mx3}), 32'hC);
    chk("l3_cnt", 32'(cnt3), 32'd3);

    // Second stall aborted by reset during its second bubble
    @(negedge clk);
    drive(LDRB_R2, 3'b110);
    #1;
    chk("ab_load", 32'({pe3, ie3, fl3, mx3}), 32'hC);
    @(negedge clk);
    drive(ADD_R2, 3'b100);
    #1;
    chk("ab_bub0", 32'({pe3, ie3, fl3, mx3}), 32'h1);
    @(negedge clk);
    #1;
    chk("ab_bub1", 32'({pe3, ie3, fl3, mx3}), 32'h1);
    chk("ab_cnt", 32'(cnt3), 32'd4);
    #1;
    reset = 1'b0;
    #1;
    chk("ab_out", 32'({pe3, ie3, fl3, mx3}), 32'hC);
    chk("ab_cnt0", 32'(cnt3), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("ab_rel", 32'({pe3, ie3, fl3, mx3}), 32'hC);
    @(negedge clk);
    #1;
    chk("ab_rel2", 32'({pe3, ie3, fl3, mx3}), 32'hC);
    chk("ab_cnt1", 32'(cnt3), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
